// File: rtl/mipi_capture_ctrl.sv
// rtl/mipi_capture_ctrl.sv - frame-aligned capture sequencer for the CSI-2 deserializer
// Gates whole frames, measures line/pixel geometry and flags stalls or ragged lines.
module mipi_capture_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int TMO_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [7:0]           num_frames,
  input  logic [TMO_WIDTH-1:0] timeout_cycles,
  input  logic                 fvi,
  input  logic                 lvi,
  input  logic                 dvi,
  output logic                 des_enable,
  output logic                 capture_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic                 line_len_err,
  output logic [7:0]           frames_done,
  output logic [CNT_WIDTH-1:0] lines_last,
  output logic [CNT_WIDTH-1:0] pixels_last
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_FS, CAPTURE, DONE} state_t;
  state_t state, state_nxt;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 fvi_q, lvi_q, des_en_q, stop_pend;
  logic [CNT_WIDTH-1:0] line_cnt, pix_cnt, ref_len;
  logic [TMO_WIDTH-1:0] tmo_cnt;

  logic                 fs, fe, le, activity, tmo_hit, last_frame;
  logic [CNT_WIDTH-1:0] pix_nxt, line_nxt;
  logic [7:0]           fd_nxt;

  assign fs       = fvi & ~fvi_q;
  assign fe       = ~fvi & fvi_q;
  assign le       = ~lvi & lvi_q;
  assign activity = dvi | (fvi ^ fvi_q) | (lvi ^ lvi_q);
  assign tmo_hit  = (timeout_cycles != '0) && (tmo_cnt == timeout_cycles - TMO_WIDTH'(1));

  assign pix_nxt    = (lvi && dvi && pix_cnt != CNT_MAX) ? pix_cnt + CNT_WIDTH'(1) : pix_cnt;
  assign line_nxt   = (line_cnt != CNT_MAX) ? line_cnt + CNT_WIDTH'(1) : line_cnt;
  assign fd_nxt     = (frames_done != 8'hFF) ? frames_done + 8'd1 : frames_done;
  assign last_frame = stop_pend || stop || (num_frames != 8'd0 && fd_nxt == num_frames);

  // The enable is cut as soon as reset is raised, not one edge later.
  assign des_enable    = des_en_q & ~reset;
  assign capture_valid = (state == CAPTURE) || (state == WAIT_FS && fs);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     if (tmo_hit || stop) state_nxt = DONE;
               else if (!fvi) state_nxt = WAIT_FS;
      WAIT_FS: if (tmo_hit || stop) state_nxt = DONE;
               else if (fs) state_nxt = CAPTURE;
      CAPTURE: if (tmo_hit) state_nxt = DONE;
               else if (fe) state_nxt = last_frame ? DONE : WAIT_FS;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fvi_q        <= 1'b0;
      lvi_q        <= 1'b0;
      des_en_q     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      line_len_err <= 1'b0;
      frames_done  <= '0;
      lines_last   <= '0;
      pixels_last  <= '0;
      line_cnt     <= '0;
      pix_cnt      <= '0;
      ref_len      <= '0;
      stop_pend    <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      state <= state_nxt;
      fvi_q <= fvi;
      lvi_q <= lvi;
      done  <= 1'b0;

      if (state == IDLE || state == DONE || activity) tmo_cnt <= '0;
      else if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);

      case (state)
        IDLE: begin
          if (start) begin
            des_en_q     <= 1'b1;
            busy         <= 1'b1;
            frames_done  <= '0;
            timeout_err  <= 1'b0;
            line_len_err <= 1'b0;
            stop_pend    <= 1'b0;
          end
        end
        ARM, WAIT_FS: begin
          if (tmo_hit) timeout_err <= 1'b1;
          else if (state == WAIT_FS && !stop && fs) begin
            line_cnt <= '0;
            pix_cnt  <= '0;
          end
        end
        CAPTURE: begin
          // An expiring timeout abandons the frame: nothing about it is recorded.
          if (tmo_hit) timeout_err <= 1'b1;
          else begin
            if (stop) stop_pend <= 1'b1;
            pix_cnt <= pix_nxt;
            if (le) begin
              pixels_last <= pix_nxt;
              pix_cnt     <= '0;
              line_cnt    <= line_nxt;
              if (line_cnt == '0) ref_len <= pix_nxt;
              else if (pix_nxt != ref_len) line_len_err <= 1'b1;
            end
            if (fe) begin
              lines_last  <= le ? line_nxt : line_cnt;
              frames_done <= fd_nxt;
            end
          end
        end
        DONE: begin
          des_en_q  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          stop_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_capture_ctrl.sv
// tb/tb_mipi_capture_ctrl.sv - bench for mipi_capture_ctrl against a frame-level reference
module tb_mipi_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stop, fvi, lvi, dvi;
  logic [7:0]  num_frames;
  logic [23:0] timeout_cycles;
  logic        des_enable, capture_valid, busy, done, timeout_err, line_len_err;
  logic [7:0]  frames_done;
  logic [15:0] lines_last, pixels_last;

  always #5 clk = ~clk;

  mipi_capture_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .num_frames(num_frames), .timeout_cycles(timeout_cycles),
    .fvi(fvi), .lvi(lvi), .dvi(dvi),
    .des_enable(des_enable), .capture_valid(capture_valid), .busy(busy),
    .done(done), .timeout_err(timeout_err), .line_len_err(line_len_err),
    .frames_done(frames_done), .lines_last(lines_last), .pixels_last(pixels_last)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc_n = 0, cv_cnt = 0, done_cnt = 0, done_cyc = 0, fe_cyc = 0;

  // Reference: tracks the sequence as "active / finishing / synced / inside a frame"
  // and keeps the current frame's line lengths in a queue.
  bit e_en, e_busy, e_done, e_terr, e_lerr;
  int e_fd, e_lines, e_pix;
  bit m_fin, m_synced, m_in_frame, m_stop_req, m_pf, m_pl;
  int m_tmo, m_cur;
  int m_lens[$];

  initial forever begin
    bit fs_s, fe_s, le_s, act_s;
    @(posedge clk);
    cyc_n++;
    fs_s  = fvi && !m_pf;
    fe_s  = !fvi && m_pf;
    le_s  = !lvi && m_pl;
    act_s = dvi || (fvi != m_pf) || (lvi != m_pl);
    e_done = 0;
    if (reset) begin
      e_en = 0; e_busy = 0; e_terr = 0; e_lerr = 0; e_fd = 0; e_lines = 0; e_pix = 0;
      m_fin = 0; m_synced = 0; m_in_frame = 0; m_stop_req = 0; m_tmo = 0; m_cur = 0;
      m_pf = 0; m_pl = 0;
    end else begin
      if (m_fin) begin
        m_fin = 0; e_busy = 0; e_en = 0; e_done = 1;
      end else if (!e_busy) begin
        if (start) begin
          e_busy = 1; e_en = 1; e_fd = 0; e_terr = 0; e_lerr = 0;
          m_synced = 0; m_in_frame = 0; m_stop_req = 0; m_tmo = 0;
        end
      end else begin
        if (timeout_cycles != 0 && m_tmo == int'(timeout_cycles) - 1) begin
          e_terr = 1; m_fin = 1;
        end else if (!m_in_frame) begin
          if (stop) m_fin = 1;
          else if (!m_synced) begin
            if (!fvi) m_synced = 1;
          end else if (fs_s) begin
            m_in_frame = 1; m_cur = 0; m_lens.delete();
          end
        end else begin
          if (stop) m_stop_req = 1;
          if (lvi && dvi) m_cur++;
          if (le_s) begin
            m_lens.push_back(m_cur);
            e_pix = m_cur;
            if (m_lens.size() > 1 && m_cur != m_lens[0]) e_lerr = 1;
            m_cur = 0;
          end
          if (fe_s) begin
            e_lines = m_lens.size();
            if (e_fd < 255) e_fd++;
            if (m_stop_req || (num_frames != 0 && e_fd == int'(num_frames))) m_fin = 1;
            else m_in_frame = 0;
          end
        end
        m_tmo = (m_fin || act_s) ? 0 : m_tmo + 1;
      end
      m_pf = fvi;
      m_pl = lvi;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic compare_all();
    bit ecv;
    ecv = e_busy && !m_fin && (m_in_frame || (m_synced && fvi && !m_pf));
    chk("des_enable", des_enable, e_en && !reset);
    chk("capture_valid", capture_valid, ecv);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("timeout_err", timeout_err, e_terr);
    chk("line_len_err", line_len_err, e_lerr);
    chk("frames_done", frames_done, e_fd);
    chk("lines_last", lines_last, e_lines);
    chk("pixels_last", pixels_last, e_pix);
    if (capture_valid) cv_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc_n; end
  endtask

  task automatic step(input logic f, input logic l, input logic d);
    fvi = f; lvi = l; dvi = d;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic send_frame(input int nl, input int len, input bit rnd_dvi,
                            input bit fe_le, input int blank, input int stop_line);
    step(1, 0, 0);
    for (int ln = 0; ln < nl; ln++) begin
      if (ln == stop_line) stop = 1'b1;
      for (int p = 0; p < len; p++) step(1, 1, rnd_dvi ? ($urandom % 4 != 0) : 1'b1);
      if (!(fe_le && ln == nl - 1)) begin
        step(1, 0, 0);
        step(1, 0, 0);
      end
    end
    fe_cyc = cyc_n;
    step(0, 0, 0);
    repeat (blank) step(0, 0, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin step(0, 0, 0); n++; end
    chk("idle_wait", busy, 0);
  endtask

  int l3[4] = '{8, 8, 7, 8};

  initial begin
    int n, cv0, d0, nfr;
    reset = 1; start = 0; stop = 0; fvi = 0; lvi = 0; dvi = 0;
    num_frames = 0; timeout_cycles = 0;
    repeat (3) step(0, 0, 0);
    chk("rst_des_enable", des_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames_done", frames_done, 0);
    reset = 0;
    repeat (2) step(0, 0, 0);

    // Two frames requested while a frame is already in flight.
    num_frames = 2;
    cv0 = cv_cnt; d0 = done_cnt;
    step(1, 0, 0);
    repeat (4) step(1, 1, 1);
    start = 1;
    repeat (4) step(1, 1, 1);
    step(1, 0, 0); step(1, 0, 0);
    repeat (8) step(1, 1, 1);
    step(1, 0, 0); step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    repeat (3) send_frame(4, 8, 0, 0, 3, -1);
    repeat (4) step(0, 0, 0);
    chk("t1_cv_cycles", cv_cnt - cv0, 84);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_frames_done", frames_done, 2);
    chk("t1_lines_last", lines_last, 4);
    chk("t1_pixels_last", pixels_last, 8);
    chk("t1_des_enable", des_enable, 0);

    // Continuous mode, stop raised inside the third frame.
    num_frames = 0;
    start = 1;
    repeat (3) step(0, 0, 0);
    send_frame(4, 8, 0, 0, 3, -1);
    send_frame(4, 8, 0, 0, 3, -1);
    send_frame(4, 8, 0, 0, 4, 2);
    chk("t2_frames_done", frames_done, 3);
    chk("t2_done_latency", done_cyc - fe_cyc, 2);
    chk("t2_busy", busy, 0);

    // Ragged frame 8,8,7,8.
    num_frames = 1;
    start = 1;
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    for (int ln = 0; ln < 4; ln++) begin
      repeat (l3[ln]) step(1, 1, 1);
      step(1, 0, 0); step(1, 0, 0);
      chk($sformatf("t3_lerr_after_line%0d", ln), line_len_err, ln >= 2);
    end
    step(0, 0, 0);
    repeat (3) step(0, 0, 0);
    chk("t3_pixels_last", pixels_last, 8);
    chk("t3_lines_last", lines_last, 4);

    // Inactivity timeout with no video at all.
    num_frames = 0; timeout_cycles = 100;
    start = 1;
    step(0, 0, 0);
    n = 0;
    while (!done && n < 300) begin step(0, 0, 0); n++; end
    chk("t4_done_after", n, 101);
    chk("t4_timeout_err", timeout_err, 1);
    chk("t4_busy", busy, 0);
    start = 1;
    step(0, 0, 0);
    chk("t4_restart_clears_err", timeout_err, 0);
    stop = 1;
    step(0, 0, 0);
    wait_idle();

    // fe coincident with le on the last line.
    timeout_cycles = 0; num_frames = 1;
    start = 1;
    repeat (3) step(0, 0, 0);
    send_frame(3, 8, 0, 1, 3, -1);
    chk("t5_lines_last", lines_last, 3);
    chk("t5_frames_done", frames_done, 1);

    // fe on the very cycle the timeout expires.
    num_frames = 0; timeout_cycles = 10;
    start = 1;
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    repeat (4) step(1, 1, 1);
    repeat (10) step(1, 0, 0);
    step(0, 0, 0);
    repeat (3) step(0, 0, 0);
    chk("t5_fe_tmo_err", timeout_err, 1);
    chk("t5_fe_tmo_frames", frames_done, 0);
    chk("t5_fe_tmo_lines_kept", lines_last, 3);

    // Reset in the middle of a captured frame.
    timeout_cycles = 0;
    start = 1;
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    repeat (3) step(1, 1, 1);
    reset = 1;
    #1;
    chk("t6_des_enable_immediate", des_enable, 0);
    step(1, 1, 1);
    chk("t6_busy", busy, 0);
    chk("t6_lines_last", lines_last, 0);
    chk("t6_capture_valid", capture_valid, 0);
    reset = 0;
    num_frames = 1;
    start = 1;
    repeat (3) step(1, 1, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (2) step(0, 0, 0);
    send_frame(2, 5, 0, 0, 3, -1);
    chk("t6_frames_done", frames_done, 1);
    chk("t6_pixels_last", pixels_last, 5);

    // Randomised sequences.
    for (int it = 0; it < 40; it++) begin
      num_frames = 8'($urandom_range(0, 3));
      timeout_cycles = ($urandom % 3 == 0) ? 24'($urandom_range(3, 40)) : 24'd0;
      start = 1;
      step(0, 0, 0);
      nfr = $urandom_range(1, 4);
      for (int f = 0; f < nfr; f++) begin
        if ($urandom % 8 == 0) stop = 1;
        if ($urandom % 6 == 0) start = 1;
        if ($urandom % 20 == 0) begin
          reset = 1;
          step(0, 0, 0);
          reset = 0;
        end
        send_frame($urandom_range(1, 4), $urandom_range(2, 9), $urandom % 2, $urandom % 2,
                   $urandom_range(1, 8), ($urandom % 5 == 0) ? $urandom_range(0, 2) : -1);
      end
      stop = 1;
      step(0, 0, 0);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1, "watchdog");
  end

endmodule
